tcdm_banked_responder: RTL and testbench

//  Synthesizable multi-port TCDM responder: the memory side of the hwpe_stream_intf_tcdm

---
 rtl/tcdm_resp_pkg.sv | 42 ++++
 rtl/tcdm_banked_responder_if.sv | 16 +
 rtl/tcdm_rr_arbiter.sv | 42 ++++
 rtl/tcdm_banked_responder.sv | 171 +++++++++++++++++
 tb/tb_tcdm_banked_responder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcdm_resp_pkg.sv
// Shared types, constants and address/LFSR helpers for the banked TCDM responder.
package tcdm_resp_pkg;

  localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_BANK,
    RSP_OOR
  } rsp_sel_e;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } tcdm_req_t;

  typedef struct packed {
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;
  } tcdm_rsp_t;

  function automatic logic [31:0] addr_to_bank(input logic [31:0] off, input int nb_log2);
    return (off >> 2) & ((32'd1 << nb_log2) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_to_row(input logic [31:0] off, input int nb_log2,
                                              input int row_log2);
    return (off >> (2 + nb_log2)) & ((32'd1 << row_log2) - 32'd1);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/tcdm_banked_responder_if.sv
// Multi-port TCDM bus: initiators drive requests (master), the responder answers (slave).
interface tcdm_banked_responder_if #(
  parameter int MP = 4
);
  logic [MP-1:0]       req;
  logic [MP-1:0][31:0] add;
  logic [MP-1:0]       wen;
  logic [MP-1:0][3:0]  be;
  logic [MP-1:0][31:0] data;
  logic [MP-1:0]       gnt;
  logic [MP-1:0][31:0] r_data;
  logic [MP-1:0]       r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter for one bank: MP requesters, at most one grant per cycle.
module tcdm_rr_arbiter #(
  parameter int MP    = 4,
  parameter int IDX_W = (MP > 1) ? $clog2(MP) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [MP-1:0]    req,
  output logic [MP-1:0]    gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int i = 0; i < MP; i++) begin
      cand = IDX_W'((int'(ptr) + i) % MP);
      if (!vld && req[cand]) begin
        vld       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (vld) begin
      ptr <= (idx == IDX_W'(MP - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/tcdm_banked_responder.sv
// Word-interleaved multi-bank TCDM responder with per-bank round-robin arbitration.
// Optional random grant stalls are enabled by defining TCDM_RESP_STALL_EN.
module tcdm_banked_responder
  import tcdm_resp_pkg::*;
#(
  parameter int          MP         = 4,
  parameter int          NB         = 8,
  parameter int          BANK_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h1c01_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  tcdm_banked_responder_if.slave  tcdm,
  output logic [15:0]             err_cnt_o
);

  localparam int          NB_W  = $clog2(NB);
  localparam int          ROW_W = $clog2(BANK_WORDS);
  localparam int          IDX_W = (MP > 1) ? $clog2(MP) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * NB * BANK_WORDS);

  tcdm_req_t        prt      [MP];
  tcdm_rsp_t        rsp      [MP];
  logic [MP-1:0]    in_range;
  logic [NB_W-1:0]  bank_of  [MP];
  logic [ROW_W-1:0] row_of   [MP];
  logic [31:0]      off;

  logic             stall;
  logic             en;
  logic [MP-1:0]    gnt;
  logic [MP-1:0]    oor_gnt;

  logic [NB-1:0][MP-1:0] bank_req;
  logic [NB-1:0][MP-1:0] bank_gnt;
  logic [NB-1:0]         bank_vld;
  logic [IDX_W-1:0]      bank_idx   [NB];
  logic [31:0]           bank_rdata [NB];

  logic [MP-1:0]    r_valid_q;
  rsp_sel_e         sel_q    [MP];
  logic [NB_W-1:0]  bank_q   [MP];
  logic [16:0]      err_sum;

`ifdef TCDM_RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) lfsr <= LFSR_SEED;
    else         lfsr <= lfsr_next(lfsr);
  end

  assign stall = (lfsr[3:0] == 4'd0);
`else
  assign stall = 1'b0;
`endif

  // Gating with reset keeps requests seen during reset from being granted.
  assign en = rst_ni & ~stall;

  always_comb begin
    off = '0;
    for (int p = 0; p < MP; p++) begin
      prt[p].req  = tcdm.req[p];
      prt[p].add  = tcdm.add[p];
      prt[p].wen  = tcdm.wen[p];
      prt[p].be   = tcdm.be[p];
      prt[p].data = tcdm.data[p];
      off         = tcdm.add[p] - BASE_ADDR;
      in_range[p] = (tcdm.add[p] >= BASE_ADDR) && (off < SPAN);
      bank_of[p]  = NB_W'(addr_to_bank(off, NB_W));
      row_of[p]   = ROW_W'(addr_to_row(off, NB_W, ROW_W));
    end
  end

  always_comb begin
    bank_req = '0;
    for (int b = 0; b < NB; b++) begin
      for (int p = 0; p < MP; p++) begin
        bank_req[b][p] = en & prt[p].req & in_range[p] & (bank_of[p] == NB_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [31:0]      mem [BANK_WORDS];
    logic [31:0]      rd_q;
    logic [IDX_W-1:0] w;

    tcdm_rr_arbiter #(.MP(MP), .IDX_W(IDX_W)) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req    (bank_req[b]),
      .gnt    (bank_gnt[b]),
      .idx    (bank_idx[b]),
      .vld    (bank_vld[b])
    );

    assign w = bank_idx[b];

    // NOTE: the SRAM array and its read register are deliberately not reset; contents survive reset.
    always_ff @(posedge clk_i) begin
      if (bank_vld[b]) begin
        if (prt[w].wen) begin
          rd_q <= mem[row_of[w]];
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (prt[w].be[i]) mem[row_of[w]][8*i +: 8] <= prt[w].data[8*i +: 8];
          end
        end
      end
    end

    assign bank_rdata[b] = rd_q;
  end

  always_comb begin
    gnt     = '0;
    oor_gnt = '0;
    for (int p = 0; p < MP; p++) begin
      oor_gnt[p] = en & prt[p].req & ~in_range[p];
      gnt[p]     = oor_gnt[p];
      for (int b = 0; b < NB; b++) gnt[p] = gnt[p] | bank_gnt[b][p];
    end
  end

  always_comb begin
    err_sum = {1'b0, err_cnt_o};
    for (int p = 0; p < MP; p++) err_sum = err_sum + 17'(oor_gnt[p]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid_q <= '0;
      err_cnt_o <= '0;
      for (int p = 0; p < MP; p++) begin
        sel_q[p]  <= RSP_NONE;
        bank_q[p] <= '0;
      end
    end else begin
      r_valid_q <= gnt;
      err_cnt_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      for (int p = 0; p < MP; p++) begin
        bank_q[p] <= bank_of[p];
        if (!gnt[p] || !prt[p].wen) sel_q[p] <= RSP_NONE;
        else if (in_range[p])       sel_q[p] <= RSP_BANK;
        else                        sel_q[p] <= RSP_OOR;
      end
    end
  end

  // Responses are masked while reset is low so a response due in the reset cycle never appears.
  always_comb begin
    for (int p = 0; p < MP; p++) begin
      rsp[p].gnt     = gnt[p];
      rsp[p].r_valid = rst_ni & r_valid_q[p];
      rsp[p].r_data  = '0;
      if (rst_ni) begin
        case (sel_q[p])
          RSP_BANK: rsp[p].r_data = bank_rdata[bank_q[p]];
          RSP_OOR:  rsp[p].r_data = OOR_RDATA;
          default:  rsp[p].r_data = '0;
        endcase
      end
      tcdm.gnt[p]     = rsp[p].gnt;
      tcdm.r_data[p]  = rsp[p].r_data;
      tcdm.r_valid[p] = rsp[p].r_valid;
    end
  end

endmodule

// File: tb/tb_tcdm_banked_responder.sv
// Directed testbench for tcdm_banked_responder (MP=4, NB=8, BANK_WORDS=1024).
module tb_tcdm_banked_responder;

  localparam int          MP   = 4;
  localparam logic [31:0] BASE = 32'h1c01_0000;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] err_cnt;
  int          total = 0;
  int          bad = 0;

  tcdm_banked_responder_if #(.MP(MP)) bus ();

  tcdm_banked_responder #(
    .MP(MP), .NB(8), .BANK_WORDS(1024), .BASE_ADDR(BASE)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .tcdm      (bus),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

`ifdef TCDM_RESP_STALL_EN
  logic [15:0] lfsr_m;
  always @(posedge clk)
    lfsr_m <= !rst_ni ? 16'hACE1
                      : {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
`endif

  task automatic idle();
    bus.req  = '0;
    bus.add  = '0;
    bus.wen  = '1;
    bus.be   = '0;
    bus.data = '0;
  endtask

  task automatic apply_reset(input int n);
    idle();
    rst_ni = 1'b0;
    repeat (n) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Single transaction on one port, entered and left at a negedge; returns what was observed.
  task automatic xfer(input int p, input logic [31:0] a, input logic wen, input logic [3:0] be,
                      input logic [31:0] d, output logic g, output logic rv,
                      output logic [31:0] rd);
    bus.req[p]  = 1'b1;
    bus.add[p]  = a;
    bus.wen[p]  = wen;
    bus.be[p]   = be;
    bus.data[p] = d;
    #1 g = bus.gnt[p];
    @(negedge clk);
    bus.req[p] = 1'b0;
    rv = bus.r_valid[p];
    rd = bus.r_data[p];
  endtask

  task automatic test_reset();
    idle();
    rst_ni  = 1'b0;
    bus.req = '1;
    for (int p = 0; p < MP; p++) bus.add[p] = BASE + 32'(4 * p);
    repeat (3) begin
      @(negedge clk);
      total++; if (bus.gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
      total++; if (bus.r_valid !== 4'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0000", bus.r_valid); end
      total++; if (err_cnt !== 16'h0) begin bad++; $display("FAIL reset_errcnt: got %h want 0000", err_cnt); end
    end
    idle();
    rst_ni = 1'b1;
    @(negedge clk);
    total++; if (bus.r_valid !== 4'b0) begin bad++; $display("FAIL reset_release_rvalid: got %b want 0000", bus.r_valid); end
  endtask

  task automatic test_single_port();
    logic g, rv;
    logic [31:0] rd;
    xfer(0, BASE, 1'b0, 4'hF, 32'h1234_5678, g, rv, rd);
    total++; if (g !== 1'b1) begin bad++; $display("FAIL single_wr_gnt: got %b want 1", g); end
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL single_wr_rvalid: got %b want 1", rv); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL single_wr_rdata: got %h want 00000000", rd); end
    xfer(0, BASE, 1'b1, 4'h0, 32'h0, g, rv, rd);
    total++; if (g !== 1'b1) begin bad++; $display("FAIL single_rd_gnt: got %b want 1", g); end
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL single_rd_rvalid: got %b want 1", rv); end
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL single_rd_data: got %h want 12345678", rd); end
    xfer(0, BASE, 1'b0, 4'b0011, 32'h0000_FFFF, g, rv, rd);
    xfer(0, BASE, 1'b1, 4'h0, 32'h0, g, rv, rd);
    total++; if (rd !== 32'h1234_FFFF) begin bad++; $display("FAIL single_be_data: got %h want 1234ffff", rd); end
    @(negedge clk);
    total++; if (bus.r_valid !== 4'b0) begin bad++; $display("FAIL single_idle_rvalid: got %b want 0000", bus.r_valid); end
  endtask

  task automatic test_conflict();
    logic g, rv;
    logic [31:0] rd;
    logic [3:0] e;
    for (int r = 1; r <= 4; r++) xfer(0, BASE + 32'(32 * r), 1'b0, 4'hF, 32'hC0DE_0000 + 32'(r), g, rv, rd);
    apply_reset(2);
    for (int p = 0; p < MP; p++) begin
      bus.req[p] = 1'b1;
      bus.wen[p] = 1'b1;
      bus.add[p] = BASE + 32'(32 * (p + 1));
    end
    for (int k = 0; k < MP; k++) begin
      e = 4'b0001 << k;
      #1;
      total++; if (bus.gnt !== e) begin bad++; $display("FAIL conflict_gnt%0d: got %b want %b", k, bus.gnt, e); end
      @(posedge clk);
      #1 bus.req[k] = 1'b0;
      @(negedge clk);
      total++; if (bus.r_valid !== e) begin bad++; $display("FAIL conflict_rvalid%0d: got %b want %b", k, bus.r_valid, e); end
      total++; if (bus.r_data[k] !== 32'hC0DE_0001 + 32'(k)) begin bad++; $display("FAIL conflict_data%0d: got %h want %h", k, bus.r_data[k], 32'hC0DE_0001 + 32'(k)); end
    end
  endtask

  task automatic test_no_conflict();
    for (int p = 0; p < MP; p++) begin
      bus.req[p]  = 1'b1;
      bus.wen[p]  = 1'b0;
      bus.be[p]   = 4'hF;
      bus.add[p]  = BASE + 32'(160 + 4 * (p + 1));
      bus.data[p] = 32'h5A00_0000 + 32'(p);
    end
    #1;
    total++; if (bus.gnt !== 4'hF) begin bad++; $display("FAIL noconf_wr_gnt: got %b want 1111", bus.gnt); end
    @(negedge clk);
    bus.req = '0;
    total++; if (bus.r_valid !== 4'hF) begin bad++; $display("FAIL noconf_wr_rvalid: got %b want 1111", bus.r_valid); end
    total++; if (bus.r_data !== '0) begin bad++; $display("FAIL noconf_wr_rdata: got %h want 0", bus.r_data); end
    bus.req = '1;
    bus.wen = '1;
    #1;
    total++; if (bus.gnt !== 4'hF) begin bad++; $display("FAIL noconf_rd_gnt: got %b want 1111", bus.gnt); end
    @(negedge clk);
    idle();
    total++; if (bus.r_valid !== 4'hF) begin bad++; $display("FAIL noconf_rd_rvalid: got %b want 1111", bus.r_valid); end
    for (int p = 0; p < MP; p++) begin
      total++; if (bus.r_data[p] !== 32'h5A00_0000 + 32'(p)) begin bad++; $display("FAIL noconf_rd_data%0d: got %h want %h", p, bus.r_data[p], 32'h5A00_0000 + 32'(p)); end
    end
  endtask

  task automatic test_out_of_range();
    logic g, rv;
    logic [31:0] rd;
    bus.req[0] = 1'b1; bus.wen[0] = 1'b1; bus.add[0] = 32'h0000_0000;
    bus.req[1] = 1'b1; bus.wen[1] = 1'b0; bus.add[1] = 32'h1c02_0000;
    bus.be[1]  = 4'hF; bus.data[1] = 32'h1111_1111;
    #1;
    total++; if (bus.gnt !== 4'b0011) begin bad++; $display("FAIL oor_gnt: got %b want 0011", bus.gnt); end
    @(negedge clk);
    idle();
    total++; if (bus.r_valid !== 4'b0011) begin bad++; $display("FAIL oor_rvalid: got %b want 0011", bus.r_valid); end
    total++; if (bus.r_data[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL oor_rd_data: got %h want deadbeef", bus.r_data[0]); end
    total++; if (bus.r_data[1] !== 32'h0) begin bad++; $display("FAIL oor_wr_rdata: got %h want 00000000", bus.r_data[1]); end
    total++; if (err_cnt !== 16'd2) begin bad++; $display("FAIL oor_errcnt2: got %0d want 2", err_cnt); end
    xfer(2, BASE, 1'b1, 4'h0, 32'h0, g, rv, rd);
    total++; if (rd !== 32'h1234_FFFF) begin bad++; $display("FAIL oor_mem_intact: got %h want 1234ffff", rd); end
    xfer(3, 32'h1c01_7FFC, 1'b0, 4'hF, 32'hFEED_F00D, g, rv, rd);
    xfer(3, 32'h1c01_7FFC, 1'b1, 4'h0, 32'h0, g, rv, rd);
    total++; if (rd !== 32'hFEED_F00D) begin bad++; $display("FAIL top_word_data: got %h want feedf00d", rd); end
    total++; if (err_cnt !== 16'd2) begin bad++; $display("FAIL top_word_errcnt: got %0d want 2", err_cnt); end
    xfer(0, 32'h1c00_FFFC, 1'b1, 4'h0, 32'h0, g, rv, rd);
    total++; if (g !== 1'b1) begin bad++; $display("FAIL below_base_gnt: got %b want 1", g); end
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL below_base_data: got %h want deadbeef", rd); end
    total++; if (err_cnt !== 16'd3) begin bad++; $display("FAIL below_base_errcnt: got %0d want 3", err_cnt); end
  endtask

  task automatic test_back_to_back();
    bus.wen[0] = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        bus.req[0] = 1'b1;
        bus.add[0] = BASE + 32'(160 + 4 * (k + 1));
      end else begin
        bus.req[0] = 1'b0;
      end
      if (k > 0) begin
        total++; if (bus.r_valid[0] !== 1'b1) begin bad++; $display("FAIL b2b_rvalid%0d: got %b want 1", k - 1, bus.r_valid[0]); end
        total++; if (bus.r_data[0] !== 32'h5A00_0000 + 32'(k - 1)) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", k - 1, bus.r_data[0], 32'h5A00_0000 + 32'(k - 1)); end
      end
      if (k < 4) begin
        #1;
        total++; if (bus.gnt[0] !== 1'b1) begin bad++; $display("FAIL b2b_gnt%0d: got %b want 1", k, bus.gnt[0]); end
        @(negedge clk);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.req[1] = 1'b1;
    bus.wen[1] = 1'b1;
    bus.add[1] = BASE;
    #1;
    total++; if (bus.gnt[1] !== 1'b1) begin bad++; $display("FAIL mid_gnt: got %b want 1", bus.gnt[1]); end
    @(posedge clk);
    #1 rst_ni = 1'b0;
    bus.req = '0;
    @(negedge clk);
    total++; if (bus.r_valid !== 4'b0) begin bad++; $display("FAIL mid_rvalid: got %b want 0000", bus.r_valid); end
    total++; if (bus.r_data !== '0) begin bad++; $display("FAIL mid_rdata: got %h want 0", bus.r_data); end
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    total++; if (bus.r_valid !== 4'b0) begin bad++; $display("FAIL mid_after_rvalid: got %b want 0000", bus.r_valid); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL mid_errcnt: got %0d want 0", err_cnt); end
  endtask

`ifdef TCDM_RESP_STALL_EN
  task automatic test_stall();
    logic g, exp_g;
    int   idx, n_got, n_exp;
    for (int i = 0; i < 16; i++) begin
      bus.req[0]  = 1'b1;
      bus.wen[0]  = 1'b0;
      bus.be[0]   = 4'hF;
      bus.add[0]  = BASE + 32'h400 + 32'(4 * i);
      bus.data[0] = 32'h57A1_0000 + 32'(i);
      g = 1'b0;
      for (int c = 0; c < 64 && !g; c++) begin
        #1 g = bus.gnt[0];
        @(negedge clk);
      end
      bus.req[0] = 1'b0;
      total++; if (g !== 1'b1) begin bad++; $display("FAIL stall_preload%0d: no grant within 64 cycles", i); end
    end
    idx = 0; n_got = 0; n_exp = 0;
    bus.req[0] = 1'b1;
    bus.wen[0] = 1'b1;
    bus.add[0] = BASE + 32'h400;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      #1;
      g     = bus.gnt[0];
      exp_g = (lfsr_m[3:0] != 4'd0);
      if (exp_g) n_exp++;
      if (g) n_got++;
      total++; if (g !== exp_g) begin bad++; $display("FAIL stall_gnt cyc %0d: got %b want %b", cyc, g, exp_g); end
      @(negedge clk);
      total++; if (bus.r_valid[0] !== g) begin bad++; $display("FAIL stall_rvalid cyc %0d: got %b want %b", cyc, bus.r_valid[0], g); end
      if (g) begin
        total++; if (bus.r_data[0] !== 32'h57A1_0000 + 32'(idx)) begin bad++; $display("FAIL stall_data cyc %0d: got %h want %h", cyc, bus.r_data[0], 32'h57A1_0000 + 32'(idx)); end
        idx = (idx + 1) % 16;
      end
      bus.add[0] = BASE + 32'h400 + 32'(4 * idx);
    end
    idle();
    total++; if (n_got != n_exp) begin bad++; $display("FAIL stall_grant_count: got %0d want %0d", n_got, n_exp); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef TCDM_RESP_STALL_EN
    test_stall();
`else
    test_single_port();
    test_conflict();
    test_no_conflict();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
